pong_game_sequencer: RTL and testbench

//  Match-level controller for the pong ball/paddle datapath. Sequences each game:

---
 rtl/pong_game_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_pong_game_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_sequencer.sv
// pong_game_sequencer
//   Match-level controller for the pong datapath. Walks each game through
//   IDLE -> SERVE -> PLAY -> POINT -> (SERVE | OVER), keeps the BCD scoreboard
//   with binary shadow counts, decides the winner and drives the ball
//   control strobes.
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   frame_tick   one-cycle pulse per video frame (paces SERVE and POINT)
//   start        button level, rising edge starts a game from IDLE/OVER
//   pause        button level, rising edge toggles PLAY/PAUSED (optional)
//   p2_mode      1 = two-player, latched on game start
//   miss_left    pulse, point to P2
//   miss_right   pulse, point to P1 (two-player only)
//   ball_run     high only in PLAY
//   ball_reset   one-cycle registered pulse: recentre ball, load serve
//   serve_dir    0 = toward P1 (left), 1 = toward P2 (right)
//   state        current state encoding (also the debug view of the FSM)
//   score        BCD {p1_tens, p1_ones, p2_tens, p2_ones}
//   winner       00 none, 01 P1, 10 P2
//
// Configuration
//   SEQ_PAUSE_EN  when defined, pause edges toggle PLAY <-> PAUSED and misses
//                 are ignored while paused. Undefined: pause is unused.
//
// Handshake: there is none; every input is a synchronous level or pulse
// sampled on the rising clock edge, and every output is a registered Moore
// output.
module pong_game_sequencer #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        pause,
  input  logic        p2_mode,
  input  logic        miss_left,
  input  logic        miss_right,
  output logic        ball_run,
  output logic        ball_reset,
  output logic        serve_dir,
  output logic [2:0]  state,
  output logic [15:0] score,
  output logic [1:0]  winner
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SERVE  = 3'd1;
  localparam logic [2:0] ST_PLAY   = 3'd2;
  localparam logic [2:0] ST_POINT  = 3'd3;
  localparam logic [2:0] ST_OVER   = 3'd4;
  localparam logic [2:0] ST_PAUSED = 3'd5;

  localparam logic [15:0] SERVE_LIM = 16'(SERVE_FRAMES);
  localparam logic [15:0] POINT_LIM = 16'(POINT_FRAMES);
  localparam logic [6:0]  WIN_LIM   = 7'(WIN_SCORE);

  logic [2:0]  state_q, state_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] score_q, score_d;
  logic [6:0]  p1_cnt_q, p1_cnt_d;
  logic [6:0]  p2_cnt_q, p2_cnt_d;
  logic [1:0]  winner_q, winner_d;
  logic        serve_dir_q, serve_dir_d;
  logic        ball_reset_q, ball_reset_d;
  logic        p2_mode_q, p2_mode_d;
  logic        start_prev_q, start_prev_d;
  logic        start_rise;

`ifdef SEQ_PAUSE_EN
  logic        pause_prev_q, pause_prev_d;
  logic        pause_rise;
  assign pause_rise = pause & ~pause_prev_q;
`else
  logic        pause_unused;
  assign pause_unused = pause;
`endif

  assign start_rise = start & ~start_prev_q;

  // Two-digit BCD increment; 99 holds (WIN_SCORE <= 99 keeps us below it).
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] != 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    score_d      = score_q;
    p1_cnt_d     = p1_cnt_q;
    p2_cnt_d     = p2_cnt_q;
    winner_d     = winner_q;
    serve_dir_d  = serve_dir_q;
    p2_mode_d    = p2_mode_q;
    ball_reset_d = 1'b0;
    start_prev_d = start;
`ifdef SEQ_PAUSE_EN
    pause_prev_d = pause;
`endif
    case (state_q)
      ST_IDLE, ST_OVER: begin
        // The ball_reset_q guard keeps the strobe from lasting two cycles when
        // a start edge lands on the cycle right after the final POINT exit.
        if (start_rise && !ball_reset_q) begin
          p2_mode_d    = p2_mode;
          score_d      = 16'h0000;
          p1_cnt_d     = 7'd0;
          p2_cnt_d     = 7'd0;
          winner_d     = 2'b00;
          serve_dir_d  = 1'b0;
          frame_cnt_d  = 16'd0;
          ball_reset_d = 1'b1;
          state_d      = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (frame_cnt_q + 16'd1 == SERVE_LIM) begin
            frame_cnt_d = 16'd0;
            state_d     = ST_PLAY;
          end else begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end
      end
      ST_PLAY: begin
        // miss_left has priority, so a simultaneous miss_right is dropped.
        // A scoring miss also outranks a pause edge in the same cycle.
        if (miss_left) begin
          p2_cnt_d      = p2_cnt_q + 7'd1;
          score_d[7:0]  = bcd_inc(score_q[7:0]);
          serve_dir_d   = 1'b0;
          frame_cnt_d   = 16'd0;
          state_d       = ST_POINT;
        end else if (miss_right && p2_mode_q) begin
          p1_cnt_d      = p1_cnt_q + 7'd1;
          score_d[15:8] = bcd_inc(score_q[15:8]);
          serve_dir_d   = 1'b1;
          frame_cnt_d   = 16'd0;
          state_d       = ST_POINT;
        end
`ifdef SEQ_PAUSE_EN
        else if (pause_rise) begin
          state_d = ST_PAUSED;
        end
`endif
      end
      ST_POINT: begin
        if (frame_tick) begin
          if (frame_cnt_q + 16'd1 == POINT_LIM) begin
            frame_cnt_d  = 16'd0;
            ball_reset_d = 1'b1;
            if (p1_cnt_q == WIN_LIM) begin
              winner_d = 2'b01;
              state_d  = ST_OVER;
            end else if (p2_cnt_q == WIN_LIM) begin
              winner_d = 2'b10;
              state_d  = ST_OVER;
            end else begin
              state_d  = ST_SERVE;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end
      end
      ST_PAUSED: begin
`ifdef SEQ_PAUSE_EN
        if (pause_rise) state_d = ST_PLAY;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      frame_cnt_q  <= 16'd0;
      score_q      <= 16'h0000;
      p1_cnt_q     <= 7'd0;
      p2_cnt_q     <= 7'd0;
      winner_q     <= 2'b00;
      serve_dir_q  <= 1'b0;
      ball_reset_q <= 1'b0;
      p2_mode_q    <= 1'b0;
      start_prev_q <= 1'b0;
`ifdef SEQ_PAUSE_EN
      pause_prev_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      score_q      <= score_d;
      p1_cnt_q     <= p1_cnt_d;
      p2_cnt_q     <= p2_cnt_d;
      winner_q     <= winner_d;
      serve_dir_q  <= serve_dir_d;
      ball_reset_q <= ball_reset_d;
      p2_mode_q    <= p2_mode_d;
      start_prev_q <= start_prev_d;
`ifdef SEQ_PAUSE_EN
      pause_prev_q <= pause_prev_d;
`endif
    end
  end

  assign state      = state_q;
  assign ball_run   = (state_q == ST_PLAY);
  assign ball_reset = ball_reset_q;
  assign serve_dir  = serve_dir_q;
  assign score      = score_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_pong_game_sequencer.sv
// tb_pong_game_sequencer
//   Directed bench for pong_game_sequencer with default parameters
//   (WIN_SCORE=7, SERVE_FRAMES=60, POINT_FRAMES=90).
module tb_pong_game_sequencer;

  localparam int SERVE_N = 60;
  localparam int POINT_N = 90;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        p2_mode = 1'b0;
  logic        miss_left = 1'b0;
  logic        miss_right = 1'b0;
  logic        ball_run;
  logic        ball_reset;
  logic        serve_dir;
  logic [2:0]  state;
  logic [15:0] score;
  logic [1:0]  winner;

  int checks = 0;
  int errors = 0;

  pong_game_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .start      (start),
    .pause      (pause),
    .p2_mode    (p2_mode),
    .miss_left  (miss_left),
    .miss_right (miss_right),
    .ball_run   (ball_run),
    .ball_reset (ball_reset),
    .serve_dir  (serve_dir),
    .state      (state),
    .score      (score),
    .winner     (winner)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    cycle();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; pause = 1'b0;
    miss_left = 1'b0; miss_right = 1'b0; frame_tick = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic start_game(input logic mode);
    p2_mode = mode;
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
  endtask

  // From SERVE with a fresh counter: release, apply a miss, run out POINT.
  task automatic play_point(input logic ml, input logic mr);
    ticks(SERVE_N);
    miss_left = ml; miss_right = mr;
    cycle();
    miss_left = 1'b0; miss_right = 1'b0;
    ticks(POINT_N);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
    checks++; if (score !== 16'h0000) begin errors++; $display("FAIL rst_score got %h exp 0000", score); end
    checks++; if (winner !== 2'b00) begin errors++; $display("FAIL rst_winner got %b exp 00", winner); end
    checks++; if ({serve_dir, ball_reset, ball_run} !== 3'b000) begin errors++; $display("FAIL rst_outs got %b exp 000", {serve_dir, ball_reset, ball_run}); end
  endtask

  task automatic test_serve();
    p2_mode = 1'b1;
    start = 1'b1;
    cycle();
    checks++; if ({state, ball_reset} !== {3'd1, 1'b1}) begin errors++; $display("FAIL serve_entry got st=%0d br=%b exp st=1 br=1", state, ball_reset); end
    start = 1'b0;
    cycle();
    checks++; if (ball_reset !== 1'b0) begin errors++; $display("FAIL serve_br_pulse got %b exp 0", ball_reset); end
    // start edge and misses in SERVE are ignored
    start = 1'b1; miss_left = 1'b1; miss_right = 1'b1;
    cycle();
    start = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
    checks++; if ({state, ball_reset, score} !== {3'd1, 1'b0, 16'h0000}) begin errors++; $display("FAIL serve_ignore got st=%0d br=%b sc=%h exp st=1 br=0 sc=0000", state, ball_reset, score); end
    ticks(SERVE_N - 1);
    checks++; if ({state, ball_run} !== {3'd1, 1'b0}) begin errors++; $display("FAIL serve_tick59 got st=%0d run=%b exp st=1 run=0", state, ball_run); end
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    checks++; if ({state, ball_run} !== {3'd2, 1'b1}) begin errors++; $display("FAIL serve_tick60 got st=%0d run=%b exp st=2 run=1", state, ball_run); end
    cycle();
  endtask

  task automatic test_point_2p();
    miss_right = 1'b1;
    cycle();
    miss_right = 1'b0;
    checks++; if ({state, ball_run} !== {3'd3, 1'b0}) begin errors++; $display("FAIL point_state got st=%0d run=%b exp st=3 run=0", state, ball_run); end
    checks++; if (score !== 16'h0100) begin errors++; $display("FAIL point_score got %h exp 0100", score); end
    checks++; if (serve_dir !== 1'b1) begin errors++; $display("FAIL point_dir got %b exp 1", serve_dir); end
    ticks(POINT_N - 1);
    checks++; if ({state, ball_reset} !== {3'd3, 1'b0}) begin errors++; $display("FAIL point_tick89 got st=%0d br=%b exp st=3 br=0", state, ball_reset); end
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    checks++; if ({state, ball_reset} !== {3'd1, 1'b1}) begin errors++; $display("FAIL point_exit got st=%0d br=%b exp st=1 br=1", state, ball_reset); end
    cycle();
    checks++; if (ball_reset !== 1'b0) begin errors++; $display("FAIL point_br_pulse got %b exp 0", ball_reset); end
  endtask

  task automatic test_reset_mid_game();
    play_point(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) play_point(1'b1, 1'b0);
    ticks(SERVE_N);
    checks++; if ({state, score, serve_dir} !== {3'd2, 16'h0203, 1'b0}) begin errors++; $display("FAIL midgame_pre got st=%0d sc=%h dir=%b exp st=2 sc=0203 dir=0", state, score, serve_dir); end
    rst_n = 1'b0;
    #1;
    checks++; if ({state, score, ball_run} !== {3'd0, 16'h0000, 1'b0}) begin errors++; $display("FAIL midgame_rst got st=%0d sc=%h run=%b exp st=0 sc=0000 run=0", state, score, ball_run); end
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_simultaneous_miss();
    start_game(1'b1);
    ticks(SERVE_N);
    miss_left = 1'b1; miss_right = 1'b1;
    cycle();
    miss_left = 1'b0; miss_right = 1'b0;
    checks++; if ({state, score, serve_dir} !== {3'd3, 16'h0001, 1'b0}) begin errors++; $display("FAIL simul got st=%0d sc=%h dir=%b exp st=3 sc=0001 dir=0", state, score, serve_dir); end
  endtask

  task automatic test_one_player_win();
    do_reset();
    start_game(1'b0);
    p2_mode = 1'b1;                     // must not affect the latched mode
    ticks(SERVE_N);
    miss_right = 1'b1;
    cycle();
    miss_right = 1'b0;
    checks++; if ({state, score} !== {3'd2, 16'h0000}) begin errors++; $display("FAIL onep_ignore got st=%0d sc=%h exp st=2 sc=0000", state, score); end
    miss_left = 1'b1;
    cycle();
    miss_left = 1'b0;
    checks++; if (score !== 16'h0001) begin errors++; $display("FAIL onep_first got %h exp 0001", score); end
    ticks(POINT_N);
    for (int i = 0; i < 5; i++) play_point(1'b1, 1'b0);
    ticks(SERVE_N);
    miss_left = 1'b1;
    cycle();
    miss_left = 1'b0;
    checks++; if ({state, score} !== {3'd3, 16'h0007}) begin errors++; $display("FAIL onep_seventh got st=%0d sc=%h exp st=3 sc=0007", state, score); end
    ticks(POINT_N - 1);
    checks++; if (winner !== 2'b00) begin errors++; $display("FAIL onep_prewin got %b exp 00", winner); end
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    checks++; if ({state, winner, ball_reset} !== {3'd4, 2'b10, 1'b1}) begin errors++; $display("FAIL onep_over got st=%0d w=%b br=%b exp st=4 w=10 br=1", state, winner, ball_reset); end
    ticks(5);
    checks++; if ({state, winner, score, ball_run} !== {3'd4, 2'b10, 16'h0007, 1'b0}) begin errors++; $display("FAIL onep_hold got st=%0d w=%b sc=%h run=%b exp st=4 w=10 sc=0007 run=0", state, winner, score, ball_run); end
    start = 1'b1;
    cycle();
    start = 1'b0;
    checks++; if ({state, winner, score, ball_reset} !== {3'd1, 2'b00, 16'h0000, 1'b1}) begin errors++; $display("FAIL onep_restart got st=%0d w=%b sc=%h br=%b exp st=1 w=00 sc=0000 br=1", state, winner, score, ball_reset); end
    cycle();
  endtask

  task automatic test_pause();
    ticks(SERVE_N);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL pause_pre got %0d exp 2", state); end
    pause = 1'b1;
    cycle();
    pause = 1'b0;
`ifdef SEQ_PAUSE_EN
    checks++; if ({state, ball_run} !== {3'd5, 1'b0}) begin errors++; $display("FAIL pause_enter got st=%0d run=%b exp st=5 run=0", state, ball_run); end
    miss_left = 1'b1;
    cycle();
    miss_left = 1'b0;
    ticks(3);
    checks++; if ({state, score} !== {3'd5, 16'h0000}) begin errors++; $display("FAIL pause_miss got st=%0d sc=%h exp st=5 sc=0000", state, score); end
    pause = 1'b1;
    cycle();
    pause = 1'b0;
    checks++; if ({state, ball_run} !== {3'd2, 1'b1}) begin errors++; $display("FAIL pause_resume got st=%0d run=%b exp st=2 run=1", state, ball_run); end
`else
    checks++; if ({state, ball_run} !== {3'd2, 1'b1}) begin errors++; $display("FAIL pause_unused got st=%0d run=%b exp st=2 run=1", state, ball_run); end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_serve();
    test_point_2p();
    test_reset_mid_game();
    test_simultaneous_miss();
    test_one_player_win();
    test_pause();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
